evt_multicast_crossbar: RTL and testbench

- Single-stage N_IN x N_OUT event crossbar. It generalises the two-stage synaptic crossbar: a per-input multicast mask replaces single-address routing, and every output has its own round-robin arbiter over all inputs and its own FIFO of configurable depth.
- Adds a per-output drop mode with saturating drop counters, for lossy spike fan-out toward the neuron engines.
- Sits between the event sources (streamers, recurrent taps) and the slice/neuron event inputs.

---
 rtl/evt_multicast_crossbar.sv | 155 +++++++++++++++
 tb/tb_evt_multicast_crossbar.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_multicast_crossbar.sv
// N_IN x N_OUT multicast event crossbar: one round-robin arbiter, FWFT FIFO and
// saturating drop counter per output; inputs retire once every masked output has served them.
module evt_xbar_out_lane #(
   parameter int DATA_WIDTH = 32,
   parameter int N_IN       = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             clr_i,
   input  logic                             drop_i,
   input  logic [N_IN-1:0]                  req_i,
   input  logic [N_IN-1:0][DATA_WIDTH-1:0]  in_data_i,
   output logic [N_IN-1:0]                  gnt_o,
   output logic                             out_valid_o,
   output logic [DATA_WIDTH-1:0]            out_data_o,
   input  logic                             out_ready_i,
   output logic [CNT_WIDTH-1:0]             drop_cnt_o
);
   localparam int RRW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);

   logic [RRW-1:0]        rr_q, sel;
   logic                  hit, full, grant, push, pop, drop_inc;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;

   // first requester at or after rr_q, wrapping
   always_comb begin
      int idx;
      idx = 0;
      hit = 1'b0;
      sel = '0;
      for (int k = 0; k < N_IN; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= N_IN) idx = idx - N_IN;
         if (!hit && req_i[idx]) begin
            hit = 1'b1;
            sel = RRW'(idx);
         end
      end
   end

   // full comes from registered occupancy so a same-cycle pop never frees a slot
   assign full     = (cnt_q == CW'(FIFO_DEPTH));
   assign grant    = hit && (!full || drop_i);
   assign push     = grant && !full;
   assign drop_inc = grant && full;
   assign out_valid_o = (cnt_q != '0);
   assign pop      = out_valid_o && out_ready_i;
   assign out_data_o  = out_valid_o ? mem_q[rd_q] : '0;

   always_comb begin
      gnt_o = '0;
      if (grant) gnt_o[sel] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= in_data_i[sel];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         drop_cnt_o <= '0;
      end else begin
         if (grant) rr_q <= (sel == RRW'(N_IN - 1)) ? '0 : sel + 1'b1;
         if (push)  wr_q <= (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
         if (pop)   rd_q <= (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
         if (clr_i)
            drop_cnt_o <= '0;
         else if (drop_inc && (drop_cnt_o != '1))
            drop_cnt_o <= drop_cnt_o + 1'b1;
      end
   end
endmodule

module evt_multicast_crossbar #(
   parameter int DATA_WIDTH = 32,
   parameter int N_IN       = 4,
   parameter int N_OUT      = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              clr_i,
   input  logic [N_IN-1:0][N_OUT-1:0]        cfg_mask_i,
   input  logic [N_OUT-1:0]                  cfg_drop_i,
   input  logic [N_IN-1:0]                   in_valid_i,
   input  logic [N_IN-1:0][DATA_WIDTH-1:0]   in_data_i,
   output logic [N_IN-1:0]                   in_ready_o,
   output logic [N_OUT-1:0]                  out_valid_o,
   output logic [N_OUT-1:0][DATA_WIDTH-1:0]  out_data_o,
   input  logic [N_OUT-1:0]                  out_ready_i,
   output logic [N_OUT-1:0][CNT_WIDTH-1:0]   drop_cnt_o,
   output logic                              busy_o
);
   logic [N_IN-1:0][N_OUT-1:0] pend_q, req_set, served, left;
   logic [N_OUT-1:0][N_IN-1:0] req, gnt;

   // the mask is only consulted while no copy of the current event is outstanding
   always_comb begin
      req = '0;
      for (int i = 0; i < N_IN; i++) begin
         req_set[i] = (pend_q[i] == '0) ? cfg_mask_i[i] : pend_q[i];
         for (int j = 0; j < N_OUT; j++) begin
            req[j][i]    = in_valid_i[i] && req_set[i][j];
            served[i][j] = gnt[j][i];
         end
         left[i]       = req_set[i] & ~served[i];
         in_ready_o[i] = in_valid_i[i] && (left[i] == '0);
      end
   end

   // left is zero on completion, so one assignment covers both retire and partial service
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         for (int i = 0; i < N_IN; i++)
            if (in_valid_i[i]) pend_q[i] <= left[i];
      end
   end

   assign busy_o = (|pend_q) || (|out_valid_o);

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      evt_xbar_out_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .N_IN       (N_IN),
         .FIFO_DEPTH (FIFO_DEPTH),
         .CNT_WIDTH  (CNT_WIDTH)
      ) u_lane (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .clr_i       (clr_i),
         .drop_i      (cfg_drop_i[j]),
         .req_i       (req[j]),
         .in_data_i   (in_data_i),
         .gnt_o       (gnt[j]),
         .out_valid_o (out_valid_o[j]),
         .out_data_o  (out_data_o[j]),
         .out_ready_i (out_ready_i[j]),
         .drop_cnt_o  (drop_cnt_o[j])
      );
   end
endmodule

// File: tb/tb_evt_multicast_crossbar.sv
// Directed bench for evt_multicast_crossbar: expected output words queued per port,
// popped and compared by a negedge monitor whenever an output transfer happens.
module tb_evt_multicast_crossbar;
   logic              clk = 1'b0;
   logic              rst_n, clr;
   logic [3:0][3:0]   mask;
   logic [3:0]        drop, in_valid, in_ready, out_valid, out_ready;
   logic [3:0][31:0]  in_data, out_data;
   logic [3:0][15:0]  drop_cnt;
   logic              busy;

   logic [0:0][0:0]   s_mask;
   logic [0:0]        s_drop, s_valid, s_ready, s_out_valid, s_out_ready;
   logic [0:0][7:0]   s_data, s_out_data;
   logic [0:0][1:0]   s_cnt;
   logic              s_busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [4][$];
   logic [3:0]  pend_seen;
   logic [3:0]  active;

   always #5 clk = ~clk;

   evt_multicast_crossbar dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .cfg_mask_i(mask), .cfg_drop_i(drop),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
      .drop_cnt_o(drop_cnt), .busy_o(busy));

   evt_multicast_crossbar #(.DATA_WIDTH(8), .N_IN(1), .N_OUT(1), .FIFO_DEPTH(1), .CNT_WIDTH(2)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .cfg_mask_i(s_mask), .cfg_drop_i(s_drop),
      .in_valid_i(s_valid), .in_data_i(s_data), .in_ready_o(s_ready),
      .out_valid_o(s_out_valid), .out_data_o(s_out_data), .out_ready_i(s_out_ready),
      .drop_cnt_o(s_cnt), .busy_o(s_busy));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int j = 0; j < 4; j++) begin
            if (out_valid[j] && out_ready[j]) begin
               if (exp_q[j].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL out%0d_unexpected: got %0h expected nothing", j, out_data[j]);
               end else begin
                  chk($sformatf("out%0d_data", j), out_data[j], exp_q[j].pop_front());
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         pend_seen <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            assert (!(pend_seen[i] && !in_valid[i]))
               else $error("protocol: valid dropped while pending on input %0d", i);
         pend_seen <= in_valid & ~in_ready;
      end
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; mask = '0; drop = '0; in_valid = '0; in_data = '0;
      out_ready = 4'hF;
      s_mask = '0; s_drop = '0; s_valid = '0; s_data = '0; s_out_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      settle();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(|out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_drop_cnt", 32'(|drop_cnt), 0);
      chk("rst_in_ready_idle", 32'(in_ready), 0);
      in_valid[0] = 1'b1;
      settle();
      chk("rst_in_ready_zero_mask", 32'(in_ready), 32'h1);
      in_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // unicast latency
      mask[0] = 4'b0001; in_valid[0] = 1'b1; in_data[0] = 32'hA5;
      exp_q[0].push_back(32'hA5);
      settle();
      chk("uni_in_ready", 32'(in_ready), 32'h1);
      chk("uni_busy_pre", 32'(busy), 0);
      tick();
      in_valid = '0; mask[0] = '0;
      settle();
      chk("uni_out_valid", 32'(out_valid), 32'h1);
      chk("uni_busy", 32'(busy), 1);
      tick();
      settle();
      chk("uni_idle", 32'(out_valid), 0);
      chk("uni_busy_post", 32'(busy), 0);

      // multicast with backpressure on output 2
      out_ready = 4'b1011; mask[3] = 4'b0100;
      in_valid[3] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_data[3] = 32'h30 + k;
         exp_q[2].push_back(32'h30 + k);
         settle();
         chk("mc_prefill_ready", 32'(in_ready[3]), 1);
         tick();
      end
      in_valid[3] = 1'b0; mask[3] = '0;
      mask[1] = 4'b0110; in_valid[1] = 1'b1; in_data[1] = 32'h11;
      exp_q[1].push_back(32'h11);
      exp_q[2].push_back(32'h11);
      settle();
      chk("mc_c0_ready", 32'(in_ready[1]), 0);
      tick();
      settle();
      chk("mc_c1_ready", 32'(in_ready[1]), 0);
      chk("mc_c1_out1", 32'(out_valid[1]), 1);
      chk("mc_c1_busy", 32'(busy), 1);
      tick();
      settle();
      chk("mc_c2_ready", 32'(in_ready[1]), 0);
      chk("mc_c2_out1_once", 32'(out_valid[1]), 0);
      tick();
      out_ready = 4'hF;
      settle();
      chk("mc_pop_cycle_ready", 32'(in_ready[1]), 0);
      tick();
      settle();
      chk("mc_after_pop_ready", 32'(in_ready[1]), 1);
      tick();
      in_valid[1] = 1'b0; mask[1] = '0;
      repeat (3) tick();
      settle();
      chk("mc_busy_drained", 32'(busy), 0);

      // round robin on output 0; rr[0] points at input 1 after the unicast test
      for (int i = 0; i < 4; i++) begin
         mask[i] = 4'b0001;
         in_data[i] = 32'h100 + i;
      end
      active = 4'hF;
      for (int k = 0; k < 12; k++) begin
         int g;
         g = (1 + k) % 4;
         in_valid = active;
         exp_q[0].push_back(32'h100 + g);
         settle();
         chk("rr_ready", 32'(in_ready), 32'(1 << g));
         if (k > 0) chk("rr_thru", 32'(out_valid[0]), 1);
         tick();
         if (k >= 8) active[g] = 1'b0;
      end
      in_valid = '0; mask = '0;
      repeat (2) tick();

      // drop mode on output 3
      drop = 4'b1000; mask[0] = 4'b1000; out_ready = 4'b0111;
      for (int k = 0; k < 5; k++) begin
         in_valid[0] = 1'b1; in_data[0] = 32'h40 + k;
         if (k < 2) exp_q[3].push_back(32'h40 + k);
         settle();
         chk("drop_ready", 32'(in_ready[0]), 1);
         tick();
      end
      in_valid = '0;
      settle();
      chk("drop_cnt3", 32'(drop_cnt[3]), 3);
      chk("drop_fifo3_valid", 32'(out_valid[3]), 1);
      clr = 1'b1; in_valid[0] = 1'b1; in_data[0] = 32'h45;
      settle();
      chk("drop_clr_ready", 32'(in_ready[0]), 1);
      tick();
      clr = 1'b0; in_valid = '0;
      settle();
      chk("drop_clr_wins", 32'(drop_cnt[3]), 0);
      out_ready = 4'hF;
      repeat (3) tick();
      drop = '0; mask[0] = '0;

      // counter saturation on a 2-bit instance
      s_drop = 1'b1; s_mask = 1'b1; s_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         s_data[0] = 8'(k + 1);
         settle();
         chk("sat_ready", 32'(s_ready), 1);
         tick();
      end
      s_valid = '0;
      settle();
      chk("sat_cnt", 32'(s_cnt), 3);
      chk("sat_out_valid", 32'(s_out_valid), 1);
      chk("sat_out_data", 32'(s_out_data), 1);
      s_out_ready = 1'b1;
      tick();

      // zero mask sink
      mask[2] = 4'b0000; in_valid[2] = 1'b1; in_data[2] = 32'h55;
      settle();
      chk("zero_ready", 32'(in_ready[2]), 1);
      tick();
      in_valid = '0;
      settle();
      chk("zero_no_out", 32'(out_valid), 0);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_no_drop", 32'(|drop_cnt), 0);

      // mask change while pending
      out_ready = 4'b1101; mask[3] = 4'b0010; in_valid[3] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_data[3] = 32'h61 + k;
         exp_q[1].push_back(32'h61 + k);
         tick();
      end
      in_valid[3] = 1'b0; mask[3] = '0;
      mask[2] = 4'b0011; in_valid[2] = 1'b1; in_data[2] = 32'h70;
      exp_q[0].push_back(32'h70);
      exp_q[1].push_back(32'h70);
      settle();
      chk("mask_m0_ready", 32'(in_ready[2]), 0);
      tick();
      mask[2] = 4'b1100;
      settle();
      chk("mask_m1_ready", 32'(in_ready[2]), 0);
      tick();
      out_ready = 4'hF;
      settle();
      chk("mask_m2_ready", 32'(in_ready[2]), 0);
      chk("mask_m2_no_23", 32'(out_valid[3:2]), 0);
      tick();
      settle();
      chk("mask_m3_ready", 32'(in_ready[2]), 1);
      tick();
      in_data[2] = 32'h71;
      exp_q[2].push_back(32'h71);
      exp_q[3].push_back(32'h71);
      settle();
      chk("mask_next_event", 32'(in_ready[2]), 1);
      tick();
      in_valid = '0; mask = '0;
      repeat (3) tick();

      // reset mid-operation
      out_ready = '0; drop = 4'b1000;
      mask[0] = 4'b0001; mask[2] = 4'b1000; mask[1] = 4'b0011;
      in_valid = 4'b0101; in_data[0] = 32'h90; in_data[2] = 32'hA0;
      tick();
      in_data[0] = 32'h91; in_data[2] = 32'hA1;
      tick();
      in_valid = 4'b0110; in_data[1] = 32'hB0; in_data[2] = 32'hA2;
      settle();
      chk("rstmid_ready", 32'(in_ready), 32'h4);
      tick();
      in_valid = 4'b0010;
      settle();
      chk("rstmid_busy", 32'(busy), 1);
      chk("rstmid_drop", 32'(drop_cnt[3]), 1);
      chk("rstmid_valid", 32'(out_valid), 32'hB);
      rst_n = 1'b0; in_valid = '0;
      #1;
      chk("rstmid_out_valid", 32'(out_valid), 0);
      chk("rstmid_busy_clr", 32'(busy), 0);
      chk("rstmid_drop_clr", 32'(|drop_cnt), 0);
      tick();
      rst_n = 1'b1; drop = '0; out_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         mask[i] = 4'hF;
         in_data[i] = 32'hC0 + i;
      end
      active = 4'hF;
      for (int k = 0; k < 4; k++) begin
         in_valid = active;
         for (int j = 0; j < 4; j++) exp_q[j].push_back(32'hC0 + k);
         settle();
         chk("post_rst_ready", 32'(in_ready), 32'(1 << k));
         tick();
         active[k] = 1'b0;
      end
      in_valid = '0; mask = '0;
      repeat (3) tick();
      settle();
      chk("final_busy", 32'(busy), 0);
      for (int j = 0; j < 4; j++)
         chk($sformatf("drain_q%0d", j), 32'(exp_q[j].size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
